// File: rtl/snake_render_pkg.sv
// Shared types and constants for the snake pixel renderer: coordinate width,
// {R,G,B} colour codes and the segment position record.
package snake_render_pkg;

    localparam int COORD_W = 11;

    localparam logic [2:0] COL_HEAD   = 3'b110;
    localparam logic [2:0] COL_BODY   = 3'b100;
    localparam logic [2:0] COL_BORDER = 3'b100;
    localparam logic [2:0] COL_FOOD   = 3'b001;
    localparam logic [2:0] COL_BG     = 3'b000;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } seg_t;

endpackage

// File: rtl/snake_pixel_renderer_if.sv
// Segment-table load port of the snake renderer: entry writes, length commit
// and the ready back-pressure driven by the renderer.
interface snake_pixel_renderer_if
    import snake_render_pkg::*;
#(
    parameter int SEG_MAX = 32
);
    localparam int IDX_W = $clog2(SEG_MAX);

    logic               seg_wr_en;
    logic               seg_wr_rdy;
    logic [IDX_W-1:0]   seg_wr_idx;
    logic [COORD_W-1:0] seg_wr_x;
    logic [COORD_W-1:0] seg_wr_y;
    logic [IDX_W:0]     seg_len;
    logic               seg_commit;

    modport master (
        output seg_wr_en,
        output seg_wr_idx,
        output seg_wr_x,
        output seg_wr_y,
        output seg_len,
        output seg_commit,
        input  seg_wr_rdy
    );

    modport slave (
        input  seg_wr_en,
        input  seg_wr_idx,
        input  seg_wr_x,
        input  seg_wr_y,
        input  seg_len,
        input  seg_commit,
        output seg_wr_rdy
    );

endinterface

// File: rtl/snake_seg_hit.sv
// Strict box test: pixel (px,py) lies inside segment box sx<px<sx+SEG_SIZE, same for y.
module snake_seg_hit
    import snake_render_pkg::*;
#(
    parameter int SEG_SIZE = 6
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    output logic               hit
);

    localparam logic [COORD_W:0] SIZE_EXT = (COORD_W+1)'(SEG_SIZE);

    // One extra bit on the far edge so a box near the top coordinate clips instead of wrapping.
    logic [COORD_W:0] sx_end;
    logic [COORD_W:0] sy_end;

    assign sx_end = {1'b0, sx} + SIZE_EXT;
    assign sy_end = {1'b0, sy} + SIZE_EXT;

    assign hit = (px > sx) && ({1'b0, px} < sx_end) &&
                 (py > sy) && ({1'b0, py} < sy_end);

endmodule

// File: rtl/snake_pixel_renderer.sv
// Snake playfield colour generator: double-buffered segment table, 2-clock pixel pipeline,
// per-frame sticky collision flag. Define SNAKE_FOOD_EN to add the food box and food_eaten.
module snake_pixel_renderer
    import snake_render_pkg::*;
#(
    parameter int SEG_MAX  = 32,
    parameter int SEG_SIZE = 6,
    parameter int BX0      = 10,
    parameter int BX1      = 300,
    parameter int BY0      = 10,
    parameter int BY1      = 310,
    parameter int BT       = 10
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  Ready_Sig,
    input  logic [COORD_W-1:0]    x_sig,
    input  logic [COORD_W-1:0]    y_sig,
    input  logic                  frame_start,
    snake_pixel_renderer_if.slave seg_if,
`ifdef SNAKE_FOOD_EN
    input  logic [COORD_W-1:0]    food_x,
    input  logic [COORD_W-1:0]    food_y,
    output logic                  food_eaten,
`endif
    output logic                  Red_Sig,
    output logic                  Green_Sig,
    output logic                  Blue_Sig,
    output logic                  collide
);

    localparam int IDX_W = $clog2(SEG_MAX);
    localparam int LEN_W = IDX_W + 1;

    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(SEG_MAX);
    localparam logic [COORD_W-1:0] BX_LO    = COORD_W'(BX0);
    localparam logic [COORD_W-1:0] BX_HI    = COORD_W'(BX1);
    localparam logic [COORD_W-1:0] BY_LO    = COORD_W'(BY0);
    localparam logic [COORD_W-1:0] BY_HI    = COORD_W'(BY1);
    localparam logic [COORD_W-1:0] BX_LO_IN = COORD_W'(BX0 + BT);
    localparam logic [COORD_W-1:0] BX_HI_IN = COORD_W'(BX1 - BT);
    localparam logic [COORD_W-1:0] BY_LO_IN = COORD_W'(BY0 + BT);
    localparam logic [COORD_W-1:0] BY_HI_IN = COORD_W'(BY1 - BT);

    seg_t [SEG_MAX-1:0] shadow_q, shadow_d;
    seg_t [SEG_MAX-1:0] active_q, active_d;
    logic [LEN_W-1:0]   shadow_len_q, shadow_len_d;
    logic [LEN_W-1:0]   active_len_q, active_len_d;
    logic               commit_pend_q, commit_pend_d;

    logic               ready_d1_q, ready_d1_d;
    logic               border_hit_q, border_hit_d;
    logic               head_hit_q, head_hit_d;
    logic               body_hit_q, body_hit_d;
    logic [2:0]         rgb_q, rgb_d;
    logic               coll_acc_q, coll_acc_d;
    logic               collide_q, collide_d;

    logic               wr_accept;
    logic               swap;
    logic [LEN_W-1:0]   commit_len;
    logic [SEG_MAX-1:0] raw_hit;
    logic [SEG_MAX-1:0] valid_hit;
    logic               border_inside;
    logic               border_near;
    logic               coll_hit;

`ifdef SNAKE_FOOD_EN
    seg_t               food_q, food_d;
    logic               food_hit_q, food_hit_d;
    logic               eat_acc_q, eat_acc_d;
    logic               food_eaten_q, food_eaten_d;
    logic               food_raw;
    logic               eat_hit;
`endif

    assign seg_if.seg_wr_rdy = !commit_pend_q;
    assign wr_accept         = seg_if.seg_wr_en && seg_if.seg_wr_rdy;
    assign commit_len        = (seg_if.seg_len > LEN_MAX) ? LEN_MAX : seg_if.seg_len;
    assign swap              = frame_start && (commit_pend_q || seg_if.seg_commit);

    // A commit arriving together with frame_start swaps immediately using its own length;
    // a write in the swap cycle only reaches the shadow copy.
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        shadow_len_d  = shadow_len_q;
        active_len_d  = active_len_q;
        commit_pend_d = commit_pend_q;
        if (wr_accept && (32'(seg_if.seg_wr_idx) < SEG_MAX)) begin
            shadow_d[seg_if.seg_wr_idx] = '{x: seg_if.seg_wr_x, y: seg_if.seg_wr_y};
        end
        if (seg_if.seg_commit) begin
            shadow_len_d  = commit_len;
            commit_pend_d = 1'b1;
        end
        if (swap) begin
            active_d      = shadow_q;
            active_len_d  = seg_if.seg_commit ? commit_len : shadow_len_q;
            commit_pend_d = 1'b0;
        end
    end

    for (genvar i = 0; i < SEG_MAX; i++) begin : g_seg
        snake_seg_hit #(
            .SEG_SIZE (SEG_SIZE)
        ) u_hit (
            .px  (x_sig),
            .py  (y_sig),
            .sx  (active_q[i].x),
            .sy  (active_q[i].y),
            .hit (raw_hit[i])
        );
        assign valid_hit[i] = raw_hit[i] && (LEN_W'(i) < active_len_q);
    end

`ifdef SNAKE_FOOD_EN
    snake_seg_hit #(
        .SEG_SIZE (SEG_SIZE)
    ) u_food_hit (
        .px  (x_sig),
        .py  (y_sig),
        .sx  (food_q.x),
        .sy  (food_q.y),
        .hit (food_raw)
    );
`endif

    assign border_inside = (x_sig > BX_LO) && (x_sig < BX_HI) &&
                           (y_sig > BY_LO) && (y_sig < BY_HI);
    assign border_near   = (x_sig < BX_LO_IN) || (x_sig > BX_HI_IN) ||
                           (y_sig < BY_LO_IN) || (y_sig > BY_HI_IN);

    // Stage 1 classifies the pixel, stage 2 picks the colour; collision flags follow frame boundaries.
    always_comb begin
        ready_d1_d   = Ready_Sig;
        border_hit_d = border_inside && border_near;
        head_hit_d   = valid_hit[0];
        body_hit_d   = |valid_hit[SEG_MAX-1:1];

        rgb_d = COL_BG;
        if (ready_d1_q) begin
            if (head_hit_q) begin
                rgb_d = COL_HEAD;
            end
`ifdef SNAKE_FOOD_EN
            else if (food_hit_q) begin
                rgb_d = COL_FOOD;
            end
`endif
            else if (body_hit_q) begin
                rgb_d = COL_BODY;
            end else if (border_hit_q) begin
                rgb_d = COL_BORDER;
            end
        end

        coll_hit = ready_d1_q && head_hit_q && (body_hit_q || border_hit_q);
        if (frame_start) begin
            collide_d  = coll_acc_q;
            coll_acc_d = coll_hit;
        end else begin
            collide_d  = collide_q;
            coll_acc_d = coll_acc_q | coll_hit;
        end

`ifdef SNAKE_FOOD_EN
        food_hit_d = food_raw;
        food_d     = food_q;
        eat_hit    = ready_d1_q && head_hit_q && food_hit_q;
        if (frame_start) begin
            food_d       = '{x: food_x, y: food_y};
            food_eaten_d = eat_acc_q;
            eat_acc_d    = eat_hit;
        end else begin
            food_eaten_d = food_eaten_q;
            eat_acc_d    = eat_acc_q | eat_hit;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_len_q  <= '0;
            active_len_q  <= '0;
            commit_pend_q <= 1'b0;
            ready_d1_q    <= 1'b0;
            border_hit_q  <= 1'b0;
            head_hit_q    <= 1'b0;
            body_hit_q    <= 1'b0;
            rgb_q         <= COL_BG;
            coll_acc_q    <= 1'b0;
            collide_q     <= 1'b0;
`ifdef SNAKE_FOOD_EN
            food_q        <= '0;
            food_hit_q    <= 1'b0;
            eat_acc_q     <= 1'b0;
            food_eaten_q  <= 1'b0;
`endif
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            shadow_len_q  <= shadow_len_d;
            active_len_q  <= active_len_d;
            commit_pend_q <= commit_pend_d;
            ready_d1_q    <= ready_d1_d;
            border_hit_q  <= border_hit_d;
            head_hit_q    <= head_hit_d;
            body_hit_q    <= body_hit_d;
            rgb_q         <= rgb_d;
            coll_acc_q    <= coll_acc_d;
            collide_q     <= collide_d;
`ifdef SNAKE_FOOD_EN
            food_q        <= food_d;
            food_hit_q    <= food_hit_d;
            eat_acc_q     <= eat_acc_d;
            food_eaten_q  <= food_eaten_d;
`endif
        end
    end

    assign {Red_Sig, Green_Sig, Blue_Sig} = rgb_q;
    assign collide                        = collide_q;
`ifdef SNAKE_FOOD_EN
    assign food_eaten                     = food_eaten_q;
`endif

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench for snake_pixel_renderer: border, head/body colours, double buffering,
// dropped writes, collision frame semantics, coordinate clipping; food checks under SNAKE_FOOD_EN.
module tb_snake_pixel_renderer;
    import snake_render_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_start;
    logic               red;
    logic               green;
    logic               blue;
    logic               collide;
`ifdef SNAKE_FOOD_EN
    logic [COORD_W-1:0] food_x;
    logic [COORD_W-1:0] food_y;
    logic               food_eaten;
`endif

    int checks = 0;
    int errors = 0;

    snake_pixel_renderer_if #(.SEG_MAX(32)) seg_if ();

    snake_pixel_renderer dut (
        .CLK         (clk),
        .RSTn        (rst_n),
        .Ready_Sig   (ready),
        .x_sig       (x),
        .y_sig       (y),
        .frame_start (frame_start),
        .seg_if      (seg_if.slave),
`ifdef SNAKE_FOOD_EN
        .food_x      (food_x),
        .food_y      (food_y),
        .food_eaten  (food_eaten),
`endif
        .Red_Sig     (red),
        .Green_Sig   (green),
        .Blue_Sig    (blue),
        .collide     (collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one qualified pixel, then idle so its colour is on RGB after the second edge.
    task automatic applyStimulus(input int px, input int py);
        x     = COORD_W'(px);
        y     = COORD_W'(py);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        x     = '0;
        y     = '0;
        tick();
    endtask

    task automatic checkPixel(input string tag, input int px, input int py, input logic [2:0] exp);
        applyStimulus(px, py);
        checkOutput(tag, {29'd0, red, green, blue}, {29'd0, exp});
    endtask

    task automatic writeSeg(input int idx, input int sx, input int sy);
        seg_if.seg_wr_en  = 1'b1;
        seg_if.seg_wr_idx = 5'(idx);
        seg_if.seg_wr_x   = COORD_W'(sx);
        seg_if.seg_wr_y   = COORD_W'(sy);
        tick();
        seg_if.seg_wr_en  = 1'b0;
    endtask

    task automatic commitLen(input int len);
        seg_if.seg_commit = 1'b1;
        seg_if.seg_len    = 6'(len);
        tick();
        seg_if.seg_commit = 1'b0;
    endtask

    task automatic pulseFrame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        ready             = 1'b0;
        x                 = '0;
        y                 = '0;
        frame_start       = 1'b0;
        seg_if.seg_wr_en  = 1'b0;
        seg_if.seg_wr_idx = '0;
        seg_if.seg_wr_x   = '0;
        seg_if.seg_wr_y   = '0;
        seg_if.seg_len    = '0;
        seg_if.seg_commit = 1'b0;
`ifdef SNAKE_FOOD_EN
        food_x            = '0;
        food_y            = '0;
`endif
        tick();
        tick();
        checkOutput("reset_rgb", {29'd0, red, green, blue}, 32'd0);
        checkOutput("reset_collide", {31'd0, collide}, 32'd0);
        checkOutput("reset_rdy", {31'd0, seg_if.seg_wr_rdy}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Border only on an empty table
        checkPixel("border_15_100", 15, 100, 3'b100);
        checkPixel("border_19_100", 19, 100, 3'b100);
        checkPixel("inner_20_100", 20, 100, 3'b000);
        checkPixel("edge_10_100", 10, 100, 3'b000);
        checkPixel("border_100_15", 100, 15, 3'b100);
        checkPixel("bg_100_100", 100, 100, 3'b000);
        checkPixel("border_295_100", 295, 100, 3'b100);
        checkPixel("edge_300_100", 300, 100, 3'b000);
        pulseFrame();
        checkOutput("collide_empty", {31'd0, collide}, 32'd0);

        // Head at (50,50): invisible until frame_start, then 2-clock latency
        writeSeg(0, 50, 50);
        commitLen(1);
        checkOutput("rdy_pending", {31'd0, seg_if.seg_wr_rdy}, 32'd0);
        checkPixel("head_pre_swap", 53, 53, 3'b000);
        pulseFrame();
        checkOutput("rdy_after_swap", {31'd0, seg_if.seg_wr_rdy}, 32'd1);
        x = 11'd53;
        y = 11'd53;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("latency_1clk", {29'd0, red, green, blue}, 32'd0);
        tick();
        checkOutput("latency_2clk", {29'd0, red, green, blue}, 32'd6);
        checkPixel("head_corner_50", 50, 50, 3'b000);
        checkPixel("head_edge_56", 56, 53, 3'b000);
        checkPixel("head_55_55", 55, 55, 3'b110);

        // Body entries and length shrink taking effect only at frame_start
        writeSeg(1, 56, 50);
        writeSeg(2, 62, 50);
        writeSeg(3, 68, 50);
        commitLen(4);
        pulseFrame();
        checkPixel("body1", 59, 53, 3'b100);
        checkPixel("body2", 65, 53, 3'b100);
        checkPixel("body3", 71, 53, 3'b100);
        commitLen(2);
        checkPixel("len2_pre_swap", 65, 53, 3'b100);
        pulseFrame();
        checkPixel("len2_body2_off", 65, 53, 3'b000);
        checkPixel("len2_body1_on", 59, 53, 3'b100);

        // Write while pending is dropped
        commitLen(2);
        checkOutput("rdy_low", {31'd0, seg_if.seg_wr_rdy}, 32'd0);
        writeSeg(1, 200, 200);
        pulseFrame();
        checkPixel("dropped_write", 203, 203, 3'b000);
        checkPixel("entry1_kept", 59, 53, 3'b100);

        // Commit, frame_start and a write all in one cycle
        writeSeg(1, 100, 150);
        seg_if.seg_commit = 1'b1;
        seg_if.seg_len    = 6'd3;
        frame_start       = 1'b1;
        seg_if.seg_wr_en  = 1'b1;
        seg_if.seg_wr_idx = 5'd2;
        seg_if.seg_wr_x   = 11'd130;
        seg_if.seg_wr_y   = 11'd150;
        tick();
        seg_if.seg_commit = 1'b0;
        frame_start       = 1'b0;
        seg_if.seg_wr_en  = 1'b0;
        checkOutput("rdy_same_cycle", {31'd0, seg_if.seg_wr_rdy}, 32'd1);
        checkPixel("same_cycle_new", 103, 153, 3'b100);
        checkPixel("swap_write_old", 65, 53, 3'b100);
        checkPixel("swap_write_absent", 133, 153, 3'b000);
        commitLen(3);
        pulseFrame();
        checkPixel("swap_write_later", 133, 153, 3'b100);
        checkPixel("swap_old_gone", 65, 53, 3'b000);

        // Length above SEG_MAX clamps to the full table
        writeSeg(31, 400, 400);
        commitLen(40);
        pulseFrame();
        checkPixel("clamp_last", 403, 403, 3'b100);

        // Head over border -> collide after the following frame_start
        writeSeg(0, 14, 100);
        commitLen(1);
        pulseFrame();
        checkOutput("collide_before", {31'd0, collide}, 32'd0);
        checkPixel("head_on_border", 16, 103, 3'b110);
        checkOutput("collide_midframe", {31'd0, collide}, 32'd0);
        pulseFrame();
        checkOutput("collide_set", {31'd0, collide}, 32'd1);
        writeSeg(0, 50, 50);
        commitLen(1);
        pulseFrame();
        checkOutput("collide_clear", {31'd0, collide}, 32'd0);

        // Hit seen in the frame_start cycle belongs to the next frame
        writeSeg(0, 14, 100);
        commitLen(1);
        pulseFrame();
        x = 11'd16;
        y = 11'd103;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checkOutput("fs_hit_deferred", {31'd0, collide}, 32'd0);
        pulseFrame();
        checkOutput("fs_hit_next", {31'd0, collide}, 32'd1);
        pulseFrame();
        checkOutput("fs_hit_cleared", {31'd0, collide}, 32'd0);

        // Unqualified pixel neither draws nor collides
        x = 11'd16;
        y = 11'd103;
        tick();
        tick();
        checkOutput("ready_low_rgb", {29'd0, red, green, blue}, 32'd0);
        x = '0;
        y = '0;
        pulseFrame();
        checkOutput("ready_low_no_coll", {31'd0, collide}, 32'd0);

        // Head overlapping its own body
        writeSeg(0, 50, 50);
        writeSeg(1, 52, 50);
        commitLen(2);
        pulseFrame();
        checkPixel("head_over_body", 54, 53, 3'b110);
        pulseFrame();
        checkOutput("collide_body", {31'd0, collide}, 32'd1);

        // Entry near the coordinate limit clips instead of wrapping
        writeSeg(0, 2045, 200);
        commitLen(1);
        pulseFrame();
        checkOutput("collide_after_body", {31'd0, collide}, 32'd0);
        checkPixel("clip_2046", 2046, 203, 3'b110);
        checkPixel("clip_2047", 2047, 203, 3'b110);
        checkPixel("clip_2045", 2045, 203, 3'b000);
        checkPixel("clip_no_wrap", 1, 203, 3'b000);

        // Zero length: border only
        commitLen(0);
        pulseFrame();
        checkPixel("len0_head_off", 2046, 203, 3'b000);
        checkPixel("len0_border", 15, 100, 3'b100);

`ifdef SNAKE_FOOD_EN
        food_x = 11'd80;
        food_y = 11'd80;
        pulseFrame();
        checkPixel("food_pixel", 83, 83, 3'b001);
        writeSeg(0, 80, 80);
        commitLen(1);
        pulseFrame();
        checkOutput("food_eaten_before", {31'd0, food_eaten}, 32'd0);
        checkPixel("head_over_food", 83, 83, 3'b110);
        pulseFrame();
        checkOutput("food_eaten_set", {31'd0, food_eaten}, 32'd1);
`endif

        // Asynchronous reset in the middle of a frame
        writeSeg(0, 50, 50);
        commitLen(1);
        pulseFrame();
        x = 11'd53;
        y = 11'd53;
        ready = 1'b1;
        tick();
        tick();
        checkOutput("pre_reset_head", {29'd0, red, green, blue}, 32'd6);
        rst_n = 1'b0;
        #2;
        checkOutput("async_reset_rgb", {29'd0, red, green, blue}, 32'd0);
        checkOutput("async_reset_rdy", {31'd0, seg_if.seg_wr_rdy}, 32'd1);
        ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checkPixel("post_reset_empty", 53, 53, 3'b000);
        checkPixel("post_reset_border", 15, 100, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
